// File: rtl/control_unit_pipe_pkg.sv
// ----------------------------------------------------------------------------
// cu_pkg
// Shared definitions for the pipelined control unit: opcode encodings, the
// control word carried through the ID/EX register, the bubble (NOP) control
// word and the issue FSM state type.
// ----------------------------------------------------------------------------
package cu_pkg;

    // Opcode encodings of the legal instruction set
    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_MUL  = 6'h03;
    localparam logic [5:0] OP_MOV  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h09;
    localparam logic [5:0] OP_SUBI = 6'h0A;
    localparam logic [5:0] OP_MULI = 6'h0B;
    localparam logic [5:0] OP_MOVI = 6'h0C;
    localparam logic [5:0] OP_CMPI = 6'h0E;
    localparam logic [5:0] OP_AND  = 6'h11;
    localparam logic [5:0] OP_OR   = 6'h12;
    localparam logic [5:0] OP_XOR  = 6'h13;
    localparam logic [5:0] OP_CMP  = 6'h14;
    localparam logic [5:0] OP_ANDI = 6'h19;
    localparam logic [5:0] OP_ORI  = 6'h1A;
    localparam logic [5:0] OP_LDR  = 6'h29;
    localparam logic [5:0] OP_LEA  = 6'h2A;
    localparam logic [5:0] OP_STR  = 6'h2B;
    localparam logic [5:0] OP_JMP  = 6'h38;
    localparam logic [5:0] OP_JEQ  = 6'h39;
    localparam logic [5:0] OP_JNE  = 6'h3A;
    localparam logic [5:0] OP_JLT  = 6'h3B;
    localparam logic [5:0] OP_JGT  = 6'h3C;
    localparam logic [5:0] OP_JGE  = 6'h3D;
    localparam logic [5:0] OP_JLE  = 6'h3E;

    // Write-back source selection
    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_MOV = 2'b10;

    typedef struct packed {
        logic [1:0] imm_src;
        logic [4:0] alu_control;
        logic [1:0] mem_to_reg;
        logic       mem_write;
        logic       reg_write;
        logic       pc_src;
        logic       alu_src;
    } ctrl_word_t;

    // Control word of a bubble: no architectural side effect
    localparam ctrl_word_t CTRL_NOP = '{
        imm_src:     2'b00,
        alu_control: 5'b00000,
        mem_to_reg:  2'b00,
        mem_write:   1'b0,
        reg_write:   1'b0,
        pc_src:      1'b0,
        alu_src:     1'b0
    };

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } cu_state_e;

    // True for the multi-cycle multiply instructions
    function automatic logic is_mul_op(input logic [5:0] op);
        return (op == OP_MUL) || (op == OP_MULI);
    endfunction

endpackage

// File: rtl/control_unit_pipe_if.sv
// ----------------------------------------------------------------------------
// control_unit_pipe_if
// Bundle between the IF/ID side of the pipeline and the control unit.
//   master : drives the ID instruction fields plus ex_stall/flush, observes
//            stall_id and the registered ID/EX control outputs
//   slave  : the control unit itself
// ----------------------------------------------------------------------------
interface control_unit_pipe_if #(
    parameter int REG_AW = 4
);
    logic              id_valid;
    logic [5:0]        opcode;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              ex_stall;
    logic              flush;

    logic              stall_id;
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic [1:0]        ex_imm_src;
    logic [4:0]        ex_alu_control;
    logic [1:0]        ex_mem_to_reg;
    logic              ex_mem_write;
    logic              ex_reg_write;
    logic              ex_pc_src;
    logic              ex_alu_src;
    logic              illegal_op;

    modport master (
        output id_valid, opcode, rs1, rs2, rd, ex_stall, flush,
        input  stall_id, ex_valid, ex_rd, ex_imm_src, ex_alu_control,
               ex_mem_to_reg, ex_mem_write, ex_reg_write, ex_pc_src,
               ex_alu_src, illegal_op
    );

    modport slave (
        input  id_valid, opcode, rs1, rs2, rd, ex_stall, flush,
        output stall_id, ex_valid, ex_rd, ex_imm_src, ex_alu_control,
               ex_mem_to_reg, ex_mem_write, ex_reg_write, ex_pc_src,
               ex_alu_src, illegal_op
    );
endinterface

// File: rtl/control_unit_pipe_decode.sv
// ----------------------------------------------------------------------------
// cu_decode
// Pure combinational opcode decoder.
//   opcode : 6-bit instruction opcode
//   ctrl   : control word (CTRL_NOP for NOP and for undefined opcodes)
//   legal  : opcode belongs to the defined instruction set
// ----------------------------------------------------------------------------
module cu_decode
    import cu_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_word_t ctrl,
    output logic       legal
);

    logic       legal_s;
    ctrl_word_t ctrl_s;

    // Legal-set lookup
    always_comb begin
        legal_s = 1'b0;
        case (opcode)
            OP_NOP, OP_ADD, OP_SUB, OP_MUL, OP_MOV,
            OP_ADDI, OP_SUBI, OP_MULI, OP_MOVI, OP_CMPI,
            OP_AND, OP_OR, OP_XOR, OP_CMP, OP_ANDI, OP_ORI,
            OP_LDR, OP_LEA, OP_STR,
            OP_JMP, OP_JEQ, OP_JNE, OP_JLT, OP_JGT, OP_JGE, OP_JLE:
                legal_s = 1'b1;
            default:
                legal_s = 1'b0;
        endcase
    end

    // Control-word fields follow directly from opcode bit groups
    always_comb begin
        ctrl_s = CTRL_NOP;
        if (legal_s && (opcode != OP_NOP)) begin
            ctrl_s.imm_src     = opcode[5:4];
            ctrl_s.alu_control = {opcode[5:4], opcode[2:0]};
            ctrl_s.alu_src     = opcode[3] | opcode[5];
            // Jumps (group 11) and stores never write the register file
            ctrl_s.reg_write   = (opcode[5:4] != 2'b11) && (opcode != OP_STR);
            ctrl_s.mem_write   = (opcode == OP_STR);
            ctrl_s.pc_src      = (opcode >= OP_JMP) && (opcode <= OP_JLE);
            if ((opcode == OP_MOV) || (opcode == OP_MOVI)) begin
                ctrl_s.mem_to_reg = MTR_MOV;
            end else if (opcode == OP_LDR) begin
                ctrl_s.mem_to_reg = MTR_MEM;
            end else begin
                ctrl_s.mem_to_reg = MTR_ALU;
            end
        end else begin
            ctrl_s = CTRL_NOP;
        end
    end

    assign ctrl  = ctrl_s;
    assign legal = legal_s;

endmodule

// File: rtl/control_unit_pipe.sv
// ----------------------------------------------------------------------------
// control_unit_pipe
// Registered, hazard-aware control unit between IF/ID and EX. Decodes the ID
// opcode and issues the control word into the ID/EX register one cycle later,
// inserting bubbles for load-use hazards and multi-cycle MUL/MULI, and
// killing the ID instruction on a taken jump (flush).
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : control_unit_pipe_if.slave -- ID fields, ex_stall, flush in;
//              stall_id (combinational) and registered ex_* / illegal_op out
// Parameters: REG_AW register-address width, MUL_LAT EX cycles per multiply,
//             HAZARD_EN enables the load-use interlock.
// ----------------------------------------------------------------------------
module control_unit_pipe
    import cu_pkg::*;
#(
    parameter int REG_AW    = 4,
    parameter int MUL_LAT   = 3,
    parameter int HAZARD_EN = 1
) (
    input  logic                clk,
    input  logic                rst,
    control_unit_pipe_if.slave  bus
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [REG_AW-1:0] RD_ZERO = {REG_AW{1'b0}};

    cu_state_e         state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    ctrl_word_t        ctrl_r, ctrl_nxt_s;
    logic              valid_r, valid_nxt_s;
    logic [REG_AW-1:0] rd_r, rd_nxt_s;
    logic              ill_r, ill_nxt_s;

    ctrl_word_t        dec_ctrl_s;
    logic              dec_legal_s;
    logic              is_mul_s;
    logic              load_use_s;
    logic              stall_id_s;

    cu_decode u_decode (
        .opcode (bus.opcode),
        .ctrl   (dec_ctrl_s),
        .legal  (dec_legal_s)
    );

    assign is_mul_s = dec_legal_s && is_mul_op(bus.opcode);

    // Load in EX whose destination is read by the instruction waiting in ID
    assign load_use_s = (HAZARD_EN != 0) && valid_r && (ctrl_r.mem_to_reg == MTR_MEM)
                        && bus.id_valid && ((rd_r == bus.rs1) || (rd_r == bus.rs2));

    // Front-end hold request; a flush releases the front end unconditionally
    always_comb begin
        stall_id_s = 1'b0;
        if (bus.flush) begin
            stall_id_s = 1'b0;
        end else if (bus.ex_stall) begin
            stall_id_s = 1'b1;
        end else if (state_r == MUL_BUSY) begin
            stall_id_s = 1'b1;
        end else if (load_use_s) begin
            stall_id_s = 1'b1;
        end else begin
            stall_id_s = 1'b0;
        end
    end

    // Next ID/EX contents and FSM transition, in priority order
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        ctrl_nxt_s  = ctrl_r;
        valid_nxt_s = valid_r;
        rd_nxt_s    = rd_r;
        ill_nxt_s   = ill_r;
        if (bus.flush) begin
            // Kill the ID instruction and abandon any multiply wait
            ctrl_nxt_s  = CTRL_NOP;
            valid_nxt_s = 1'b0;
            rd_nxt_s    = RD_ZERO;
            ill_nxt_s   = 1'b0;
            state_nxt_s = RUN;
            cnt_nxt_s   = CNT_ZERO;
        end else if (bus.ex_stall) begin
            // Downstream frozen: every register keeps its value
            state_nxt_s = state_r;
        end else if (state_r == MUL_BUSY) begin
            ctrl_nxt_s  = CTRL_NOP;
            valid_nxt_s = 1'b0;
            rd_nxt_s    = RD_ZERO;
            ill_nxt_s   = 1'b0;
            if (cnt_r <= CNT_ONE) begin
                state_nxt_s = RUN;
                cnt_nxt_s   = CNT_ZERO;
            end else begin
                cnt_nxt_s   = cnt_r - CNT_ONE;
            end
        end else if (load_use_s || !bus.id_valid) begin
            ctrl_nxt_s  = CTRL_NOP;
            valid_nxt_s = 1'b0;
            rd_nxt_s    = RD_ZERO;
            ill_nxt_s   = 1'b0;
        end else if (dec_legal_s) begin
            ctrl_nxt_s  = dec_ctrl_s;
            valid_nxt_s = 1'b1;
            rd_nxt_s    = bus.rd;
            ill_nxt_s   = 1'b0;
            // The multiply occupies EX for MUL_LAT cycles; the first is this issue
            if (is_mul_s && (MUL_LAT > 1)) begin
                state_nxt_s = MUL_BUSY;
                cnt_nxt_s   = CNT_LOAD;
            end else begin
                state_nxt_s = RUN;
            end
        end else begin
            // Undefined opcode: issue nothing, flag it for one cycle
            ctrl_nxt_s  = CTRL_NOP;
            valid_nxt_s = 1'b0;
            rd_nxt_s    = RD_ZERO;
            ill_nxt_s   = 1'b1;
        end
    end

    // ID/EX register, FSM state and multiply counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RUN;
            cnt_r   <= CNT_ZERO;
            ctrl_r  <= CTRL_NOP;
            valid_r <= 1'b0;
            rd_r    <= RD_ZERO;
            ill_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ctrl_r  <= ctrl_nxt_s;
            valid_r <= valid_nxt_s;
            rd_r    <= rd_nxt_s;
            ill_r   <= ill_nxt_s;
        end
    end

    assign bus.stall_id       = stall_id_s;
    assign bus.ex_valid       = valid_r;
    assign bus.ex_rd          = rd_r;
    assign bus.ex_imm_src     = ctrl_r.imm_src;
    assign bus.ex_alu_control = ctrl_r.alu_control;
    assign bus.ex_mem_to_reg  = ctrl_r.mem_to_reg;
    assign bus.ex_mem_write   = ctrl_r.mem_write;
    assign bus.ex_reg_write   = ctrl_r.reg_write;
    assign bus.ex_pc_src      = ctrl_r.pc_src;
    assign bus.ex_alu_src     = ctrl_r.alu_src;
    assign bus.illegal_op     = ill_r;

endmodule
